// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, two asynchronous read ports with
// write-through bypass, and a self-timed clear sweep started by reset or CLR.
module reg_file_mp #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  DIN,
  input  logic [ADDR_W-1:0] RD_ADDR_X,
  input  logic [ADDR_W-1:0] RD_ADDR_Y,
  input  logic              CLR,
  output logic [WIDTH-1:0]  DX_OUT,
  output logic [WIDTH-1:0]  DY_OUT,
  output logic              BUSY,
  output logic              WR_DROP
);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                wr_accept;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_accept = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = WR_ADDR;
    mem_wdata = DIN;

    unique case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end else if (WR) begin
          wr_accept = !RST;
          mem_we    = !RST;
        end
      end
      SWEEP: begin
        mem_we    = !RST;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_drop_d = WR && !wr_accept;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
    wr_drop_q <= wr_drop_d;
  end

  // NOTE: the array has no reset branch; it is cleared by the sweep instead,
  // which keeps it mappable to plain RAM cells.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Reads are forced to zero while sweeping; an accepted write bypasses to
  // a port reading the same address in the same cycle.
  always_comb begin
    if (state_q == SWEEP) begin
      DX_OUT = '0;
      DY_OUT = '0;
    end else begin
      DX_OUT = (wr_accept && (WR_ADDR == RD_ADDR_X)) ? DIN : mem_q[RD_ADDR_X];
      DY_OUT = (wr_accept && (WR_ADDR == RD_ADDR_Y)) ? DIN : mem_q[RD_ADDR_Y];
    end
  end

  assign BUSY    = (state_q == SWEEP);
  assign WR_DROP = wr_drop_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed vectors with literal expectations plus a
// per-cycle comparison against an array/counter model of the register file.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance (8 x 32)
  logic        rst, wr, clr;
  logic [4:0]  wa, rx, ry;
  logic [7:0]  din, dx, dy;
  logic        busy, drop;

  reg_file_mp dut (
    .CLK(clk), .RST(rst), .WR(wr), .WR_ADDR(wa), .DIN(din),
    .RD_ADDR_X(rx), .RD_ADDR_Y(ry), .CLR(clr),
    .DX_OUT(dx), .DY_OUT(dy), .BUSY(busy), .WR_DROP(drop)
  );

  // Small instance (16 x 4)
  logic        s_rst, s_wr, s_clr;
  logic [1:0]  s_wa, s_rx, s_ry;
  logic [15:0] s_din, s_dx, s_dy;
  logic        s_busy, s_drop;

  reg_file_mp #(.WIDTH(16), .DEPTH(4)) dut_s (
    .CLK(clk), .RST(s_rst), .WR(s_wr), .WR_ADDR(s_wa), .DIN(s_din),
    .RD_ADDR_X(s_rx), .RD_ADDR_Y(s_ry), .CLR(s_clr),
    .DX_OUT(s_dx), .DY_OUT(s_dy), .BUSY(s_busy), .WR_DROP(s_drop)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: contents array plus count of sweep cycles still to run.
  logic [7:0] m_mem [32];
  int         m_left;
  logic       m_drop;
  bit         m_valid;

  initial begin
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_left  = 0;
    m_drop  = 1'b0;
    m_valid = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_left  = 32;
      m_drop  = wr;
      m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_mem[32 - m_left] = 8'h00;
      m_left--;
      m_drop = wr;
    end else if (clr) begin
      m_left = 32;
      m_drop = wr;
    end else begin
      if (wr) m_mem[wa] = din;
      m_drop = 1'b0;
    end
  end

  function automatic logic [7:0] model_read(input logic [4:0] a);
    if (m_left > 0) return 8'h00;
    if (wr && !clr && !rst && (wa == a)) return din;
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_dx",   32'(dx),   32'(model_read(rx)));
      check("cmp_dy",   32'(dy),   32'(model_read(ry)));
      check("cmp_busy", 32'(busy), 32'(m_left > 0));
      check("cmp_drop", 32'(drop), 32'(m_drop));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic s_busy_len(output int n);
    n = 0;
    while (s_busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic write(input logic [4:0] a, input logic [7:0] d);
    wr = 1'b1; wa = a; din = d;
    step();
    wr = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; wr = 1'b0; clr = 1'b0; wa = '0; rx = '0; ry = '0; din = '0;
    s_rst = 1'b1; s_wr = 1'b0; s_clr = 1'b0; s_wa = '0; s_rx = '0; s_ry = '0; s_din = '0;

    // Reset sweep
    step();
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_dx",   32'(dx),   32'd0);
    check("rst_dy",   32'(dy),   32'd0);
    busy_len(n);
    check("rst_sweep_len", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rx = 5'(i); ry = 5'(31 - i);
      #1;
      check("rst_zero_x", 32'(dx), 32'd0);
      check("rst_zero_y", 32'(dy), 32'd0);
    end

    // Register 0 is writable; both ports agree on one address
    write(5'd0, 8'h5A);
    rx = 5'd0; ry = 5'd0;
    #1;
    check("reg0_x", 32'(dx), 32'h5A);
    check("reg0_y", 32'(dy), 32'h5A);

    // Bypass
    write(5'd6, 8'h3C);
    wr = 1'b1; wa = 5'd5; din = 8'hA7; rx = 5'd5; ry = 5'd6;
    #1;
    check("byp_dx", 32'(dx), 32'hA7);
    check("byp_dy", 32'(dy), 32'h3C);
    step();
    wr = 1'b0;
    #1;
    check("byp_next_dx", 32'(dx), 32'hA7);

    // WR and CLR collide in IDLE
    write(5'd3, 8'h11);
    wr = 1'b1; wa = 5'd3; din = 8'h55; clr = 1'b1;
    step();
    wr = 1'b0; clr = 1'b0;
    #1;
    check("col_drop", 32'(drop), 32'd1);
    check("col_busy", 32'(busy), 32'd1);
    busy_len(n);
    check("col_sweep_len", 32'(n), 32'd32);
    rx = 5'd3;
    #1;
    check("col_ram3", 32'(dx), 32'd0);

    // Write during sweep at cycle 10
    write(5'd31, 8'h77);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    wr = 1'b1; wa = 5'd31; din = 8'hFF; rx = 5'd31;
    #1;
    check("sw_dx_zero", 32'(dx), 32'd0);
    step();
    wr = 1'b0;
    #1;
    check("sw_drop", 32'(drop), 32'd1);
    step();
    check("sw_drop_clr", 32'(drop), 32'd0);
    n = 0;
    while (busy && n < 100) begin
      check("sw_dx_during", 32'(dx), 32'd0);
      n++;
      step();
    end
    check("sw_tail_len", 32'(n), 32'd20);
    check("sw_ram31", 32'(dx), 32'd0);

    // Mid-sweep reset at cycle 20, CLR pulses during the sweep
    write(5'd9, 8'hC3);
    clr = 1'b1;
    step();
    for (int k = 1; k <= 20; k++) begin
      clr = (k == 5 || k == 15);
      step();
    end
    clr = 1'b0;
    rst = 1'b1; wr = 1'b1; wa = 5'd9; din = 8'h99;
    step();
    rst = 1'b0; wr = 1'b0;
    #1;
    check("mrst_drop", 32'(drop), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      clr = (n == 3 || n == 10);
      n++;
      step();
    end
    clr = 1'b0;
    check("mrst_sweep_len", 32'(n), 32'd32);
    rx = 5'd9;
    #1;
    check("mrst_ram9", 32'(dx), 32'd0);

    // Parametric instance
    s_rst = 1'b0;
    #1;
    check("s_rst_busy", 32'(s_busy), 32'd1);
    s_busy_len(n);
    check("s_rst_len", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      s_wr = 1'b1; s_wa = 2'(i); s_din = 16'hBEEF;
      step();
    end
    s_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rx = 2'(i); s_ry = 2'(3 - i);
      #1;
      check("s_rd_x", 32'(s_dx), 32'hBEEF);
      check("s_rd_y", 32'(s_dy), 32'hBEEF);
    end
    s_wr = 1'b1; s_wa = 2'd2; s_din = 16'h0F0F;
    step();
    s_wr = 1'b0; s_rx = 2'd2; s_ry = 2'd1;
    #1;
    check("s_addr2", 32'(s_dx), 32'h0F0F);
    check("s_addr1", 32'(s_dy), 32'hBEEF);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    s_busy_len(n);
    check("s_clr_len", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      s_rx = 2'(i); s_ry = 2'(i);
      #1;
      check("s_zero_x", 32'(s_dx), 32'd0);
      check("s_zero_y", 32'(s_dy), 32'd0);
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
